// File: rtl/shift_sequencer.sv
// Multi-cycle rotate controller for the 8-bit shift unit.
// One shifter pass per clock; the result is fed back into the accumulator.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] amt,
  input  logic [WIDTH-1:0] din,
  output logic             fbus,
  output logic             flbus,
  output logic             frbus,
  output logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] w,
  input  logic             cf,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           next;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             dir_r;
  logic             last;

  assign a    = acc;
  assign last = (cnt <= CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  // cnt==0 in RUN marks a zero-amount request: a single pass-through.
  always_comb begin
    next  = state;
    fbus  = 1'b0;
    flbus = 1'b0;
    frbus = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == '0) fbus = 1'b1;
        else if (dir_r) frbus = 1'b1;
        else flbus = 1'b1;
        if (last) next = S_DONE;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      dir_r <= 1'b0;
      dout  <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= din;
            cnt   <= amt;
            dir_r <= dir;
          end
        end
        S_RUN: begin
          acc  <= w;
          cout <= cf;
          if (cnt != '0) cnt <= cnt - 1'b1;
          // dout is captured on the final pass so it is valid with done
          if (last) dout <= w;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer.
// Models the shift unit and checks rotate results against plain arithmetic.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dir;
  logic [2:0] amt;
  logic [7:0] din;
  logic       fbus, flbus, frbus;
  logic [7:0] a;
  logic [7:0] w;
  logic       cf;
  logic [7:0] dout;
  logic       cout, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .dir  (dir),
    .amt  (amt),
    .din  (din),
    .fbus (fbus),
    .flbus(flbus),
    .frbus(frbus),
    .a    (a),
    .w    (w),
    .cf   (cf),
    .dout (dout),
    .cout (cout),
    .busy (busy),
    .done (done)
  );

  // shift unit: one rotate step per enabled pass, carry = bit moved around
  always_comb begin
    w  = 8'h00;
    cf = 1'b0;
    if (fbus) begin
      w = a;
    end else if (flbus) begin
      w  = {a[6:0], a[7]};
      cf = a[7];
    end else if (frbus) begin
      w  = {a[0], a[7:1]};
      cf = a[0];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones({fbus, flbus, frbus}) > 1) begin
        errors++;
        $display("FAIL onehot: enables=%b required at most one high",
                 {fbus, flbus, frbus});
      end
    end
  end

  function automatic logic [7:0] ref_rot(logic [7:0] x, logic d, int k);
    int v;
    int r;
    v = int'(x);
    if (!d) r = (v << k) | (v >> (8 - k));
    else    r = (v >> k) | (v << (8 - k));
    return 8'(r & 255);
  endfunction

  function automatic logic ref_cout(logic [7:0] r, logic d, int k);
    if (k == 0) return 1'b0;
    return d ? r[7] : r[0];
  endfunction

  task automatic do_op(input logic [7:0] x, input logic d, input int k,
                       input bit hold, input int poke,
                       output logic [7:0] od, output logic oc,
                       output int lat, output int nl, output int nr,
                       output int nb, output bit ok);
    @(negedge clk);
    din = x; dir = d; amt = 3'(k); start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    lat = 0; nl = 0; nr = 0; nb = 0; ok = 1'b0; od = '0; oc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        od = dout; oc = cout; ok = 1'b1;
        break;
      end
      nl += int'(flbus); nr += int'(frbus); nb += int'(fbus);
      if (poke > 0 && lat == poke) begin
        start = 1'b1; din = 8'hFF; dir = ~d; amt = 3'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
  endtask

  task automatic check_op(input string nm, input logic [7:0] x,
                          input logic d, input int k, input bit hold,
                          input int poke);
    logic [7:0] od, er;
    logic       oc, ec;
    int         lat, nl, nr, nb, el, erc, eb;
    bit         ok;
    do_op(x, d, k, hold, poke, od, oc, lat, nl, nr, nb, ok);
    er  = ref_rot(x, d, k);
    ec  = ref_cout(er, d, k);
    eb  = (k == 0) ? 1 : 0;
    el  = (k > 0 && !d) ? k : 0;
    erc = (k > 0 && d) ? k : 0;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no done within 40 cycles, required done", nm);
    end
    checks++;
    if (od !== er) begin
      errors++;
      $display("FAIL %s dout: got %h required %h", nm, od, er);
    end
    checks++;
    if (oc !== ec) begin
      errors++;
      $display("FAIL %s cout: got %b required %b", nm, oc, ec);
    end
    checks++;
    if (lat != ((k == 0) ? 1 : k) + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", nm, lat,
               ((k == 0) ? 1 : k) + 1);
    end
    checks++;
    if (nb != eb || nl != el || nr != erc) begin
      errors++;
      $display("FAIL %s enables: got f/l/r=%0d/%0d/%0d required %0d/%0d/%0d",
               nm, nb, nl, nr, eb, el, erc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dir = 1'b0; amt = '0; din = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({fbus, flbus, frbus, busy, done, cout} !== 6'b0 ||
        dout !== 8'h00 || a !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: en/busy/done/cout=%b dout=%h a=%h required 0",
               {fbus, flbus, frbus, busy, done, cout}, dout, a);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({fbus, flbus, frbus, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle: en/busy/done=%b required 0",
               {fbus, flbus, frbus, busy, done});
    end
  endtask

  task automatic test_directed();
    logic [7:0] xs[4] = '{8'h81, 8'h01, 8'hB4, 8'h3C};
    logic       ds[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int         ks[4] = '{1, 3, 7, 0};
    for (int i = 0; i < 4; i++) check_op($sformatf("dir%0d", i), xs[i], ds[i], ks[i], 1'b0, 0);
  endtask

  task automatic test_ignore_start();
    check_op("ignore", 8'h01, 1'b1, 3, 1'b0, 1);
    check_op("ignore2", 8'hA7, 1'b0, 5, 1'b0, 3);
  endtask

  task automatic test_random();
    logic [7:0] held;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] x;
      logic       d;
      int         k;
      x = 8'($urandom);
      d = 1'($urandom);
      k = int'($urandom_range(0, 7));
      check_op($sformatf("rnd%0d", i), x, d, k, 1'b0, 0);
      held = ref_rot(x, d, k);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      checks++;
      if (dout !== held || busy !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d hold: dout=%h busy=%b required %h busy 0",
                 i, dout, busy, held);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] od, e1, e2;
    logic       oc;
    int         lat, nl, nr, nb;
    bit         ok;
    do_op(8'h96, 1'b0, 2, 1'b1, 0, od, oc, lat, nl, nr, nb, ok);
    e1 = ref_rot(8'h96, 1'b0, 2);
    checks++;
    if (ok !== 1'b1 || od !== e1) begin
      errors++;
      $display("FAIL b2b_first: ok=%b dout=%h required 1 %h", ok, od, e1);
    end
    din = 8'h5A; dir = 1'b1; amt = 3'd4;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== e1) begin
      errors++;
      $display("FAIL b2b_gap: busy=%b done=%b dout=%h required 0 0 %h",
               busy, done, dout, e1);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    e2 = ref_rot(8'h5A, 1'b1, 4);
    checks++;
    if (ok !== 1'b1 || dout !== e2 || cout !== ref_cout(e2, 1'b1, 4)) begin
      errors++;
      $display("FAIL b2b_second: ok=%b dout=%h cout=%b required 1 %h %b",
               ok, dout, cout, e2, ref_cout(e2, 1'b1, 4));
    end
  endtask

  task automatic test_mid_run_reset();
    @(negedge clk);
    din = 8'h33; dir = 1'b0; amt = 3'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({fbus, flbus, frbus, busy, done, cout} !== 6'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL midrst: en/busy/done/cout=%b dout=%h required 0",
               {fbus, flbus, frbus, busy, done, cout}, dout);
    end
    @(negedge clk);
    rst = 1'b0;
    check_op("after_rst", 8'hC3, 1'b1, 2, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_random();
    test_back_to_back();
    test_mid_run_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
